// File: rtl/rx_chan_scheduler_if.sv
// Scheduler <-> packet former / channel FIFO bundle.
// The master modport is the scheduler side; slave is the former/FIFO side.
interface rx_chan_scheduler_if #(
    parameter int unsigned NUM_CHAN = 2
);
    logic                         enable;
    logic [3:0]                   channels;
    logic [10*(NUM_CHAN+1)-1:0]   chan_usedw_flat;
    logic [NUM_CHAN:0]            chan_empty;
    logic                         have_space;
    logic                         pkt_done;
    logic                         start;
    logic [3:0]                   sel_chan;
    logic                         partial;
    logic [NUM_CHAN:0]            overrun;
    logic [NUM_CHAN:0]            overrun_clr;
    logic                         err_timeout;
    logic [7:0]                   debugbus;

    modport master (
        input  enable, channels, chan_usedw_flat, chan_empty, have_space, pkt_done, overrun_clr,
        output start, sel_chan, partial, overrun, err_timeout, debugbus
    );

    modport slave (
        output enable, channels, chan_usedw_flat, chan_empty, have_space, pkt_done, overrun_clr,
        input  start, sel_chan, partial, overrun, err_timeout, debugbus
    );
endinterface

// File: rtl/rx_chan_scheduler.sv
// Picks the RX channel FIFO the packet former drains next: channel 0 has strict priority,
// data channels share round-robin, and a lingering partial channel is flushed after an age timeout.
module rx_chan_scheduler #(
    parameter int unsigned NUM_CHAN      = 2,
    parameter int unsigned FULL_THRESH   = 504,
    parameter int unsigned FLUSH_TIMEOUT = 4096,
    parameter int unsigned DONE_TIMEOUT  = 1024
) (
    input logic                 rxclk,
    input logic                 reset,
    rx_chan_scheduler_if.master bus
);

    typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StHold = 2'd2} state_e;

    localparam int unsigned DoneW    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [12:0] FlushMax = 13'(FLUSH_TIMEOUT);
    localparam logic [9:0]  FullLvl  = 10'(FULL_THRESH);

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic              partial_q, partial_d;
    logic              err_q, err_d;
    logic [3:0]        sel_q, sel_d;
    logic [2:0]        rr_q, rr_d;
    logic [NUM_CHAN:0] ovr_q, ovr_d;
    logic [DoneW-1:0]  cnt_q, cnt_d;
    logic [12:0]       age_q [1:NUM_CHAN];
    logic [12:0]       age_d [1:NUM_CHAN];

    logic [3:0]        ch_max;
    logic [NUM_CHAN:0] full_vec, elig;
    logic              any_elig, pick_full, grant_done;
    logic [3:0]        pick, idx;

    always_comb begin
        ch_max   = (bus.channels > 4'(NUM_CHAN)) ? 4'(NUM_CHAN) : bus.channels;
        full_vec = '0;
        elig     = '0;
        for (int c = 0; c <= NUM_CHAN; c++) begin
            full_vec[c] = (4'(c) <= ch_max) && (bus.chan_usedw_flat[10*c +: 10] >= FullLvl);
        end
        elig[0] = ~bus.chan_empty[0];
        for (int c = 1; c <= NUM_CHAN; c++) begin
            elig[c] = (4'(c) <= ch_max) &&
                      (full_vec[c] || (~bus.chan_empty[c] && age_q[c] == FlushMax));
        end
    end

    // Walk the data channels starting after rr_ptr, wrapping from ch_max back to 1.
    always_comb begin
        any_elig  = elig[0];
        pick      = '0;
        pick_full = full_vec[0];
        idx       = {1'b0, rr_q};
        for (int k = 0; k < NUM_CHAN; k++) begin
            idx = (idx >= ch_max) ? 4'd1 : idx + 4'd1;
            for (int c = 1; c <= NUM_CHAN; c++) begin
                if (!any_elig && idx == 4'(c) && elig[c]) begin
                    any_elig  = 1'b1;
                    pick      = 4'(c);
                    pick_full = full_vec[c];
                end
            end
        end
    end

    assign grant_done = (state_q == StBusy) && bus.pkt_done;

    always_comb begin
        for (int c = 1; c <= NUM_CHAN; c++) begin
            age_d[c] = age_q[c];
            if (bus.chan_empty[c] || 4'(c) > ch_max || (grant_done && sel_q == 4'(c))) begin
                age_d[c] = '0;
            end else if (age_q[c] < FlushMax) begin
                age_d[c] = age_q[c] + 13'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        sel_d     = sel_q;
        partial_d = partial_q;
        rr_d      = rr_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        // A new overrun wins over a coincident clear.
        ovr_d     = (ovr_q & ~bus.overrun_clr) | (bus.have_space ? '0 : full_vec);
        unique case (state_q)
            StIdle: begin
                if (bus.enable && any_elig && bus.have_space) begin
                    sel_d     = pick;
                    partial_d = ~pick_full;
                    start_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (bus.pkt_done) begin
                    if (sel_q != 4'd0) rr_d = sel_q[2:0];
                    state_d = StHold;
                end else if (cnt_q == DoneW'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                partial_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            sel_q     <= '0;
            partial_q <= 1'b0;
            rr_q      <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            ovr_q     <= '0;
            for (int c = 1; c <= NUM_CHAN; c++) age_q[c] <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            sel_q     <= sel_d;
            partial_q <= partial_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            for (int c = 1; c <= NUM_CHAN; c++) age_q[c] <= age_d[c];
        end
    end

    assign bus.start       = start_q;
    assign bus.sel_chan    = sel_q;
    assign bus.partial     = partial_q;
    assign bus.overrun     = ovr_q;
    assign bus.err_timeout = err_q;
    assign bus.debugbus    = {state_q, rr_q, bus.have_space, |full_vec, start_q};

endmodule

// File: tb/tb_rx_chan_scheduler.sv
// Directed + randomized bench for rx_chan_scheduler, checked every cycle against a
// behavioural model of the grant rules.
module tb_rx_chan_scheduler;
    localparam int NC    = 2;
    localparam int FULL  = 504;
    localparam int FLUSH = 4096;
    localparam int DONE  = 1024;

    logic rxclk = 1'b0;
    logic reset = 1'b1;
    always #5 rxclk = ~rxclk;

    rx_chan_scheduler_if #(.NUM_CHAN(NC)) bus ();

    rx_chan_scheduler #(
        .NUM_CHAN     (NC),
        .FULL_THRESH  (FULL),
        .FLUSH_TIMEOUT(FLUSH),
        .DONE_TIMEOUT (DONE)
    ) dut (
        .rxclk(rxclk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int usedw [NC+1];
    int exp_rr [4] = '{1, 2, 1, 2};

    // Model state: what the outputs must be after the most recent edge.
    bit      m_start, m_partial, m_err, m_busy, m_hold, m_fullany;
    int      m_sel, m_rr, m_elapsed;
    bit [NC:0] m_ov;
    int      m_age [NC+1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int cmax, pick, best, d;
        bit full [NC+1];
        bit elig [NC+1];
        cmax = (int'(bus.channels) > NC) ? NC : int'(bus.channels);
        m_fullany = 1'b0;
        for (int c = 0; c <= NC; c++) begin
            full[c] = (c <= cmax) && (usedw[c] >= FULL);
            m_fullany |= full[c];
        end
        elig[0] = !bus.chan_empty[0];
        for (int c = 1; c <= NC; c++)
            elig[c] = (c <= cmax) && (full[c] || (!bus.chan_empty[c] && m_age[c] == FLUSH));
        if (reset) begin
            m_start = 0; m_sel = 0; m_partial = 0; m_err = 0; m_rr = 0;
            m_busy = 0; m_hold = 0; m_elapsed = 0; m_ov = '0;
            for (int c = 0; c <= NC; c++) m_age[c] = 0;
            return;
        end
        for (int c = 0; c <= NC; c++) begin
            if (!bus.have_space && full[c]) m_ov[c] = 1'b1;
            else if (bus.overrun_clr[c]) m_ov[c] = 1'b0;
        end
        for (int c = 1; c <= NC; c++) begin
            if (bus.chan_empty[c] || c > cmax || (m_busy && bus.pkt_done && m_sel == c))
                m_age[c] = 0;
            else if (m_age[c] < FLUSH) m_age[c]++;
        end
        m_start = 0;
        if (m_busy) begin
            if (bus.pkt_done) begin
                if (m_sel != 0) m_rr = m_sel;
                m_busy = 0; m_hold = 1;
            end else if (m_elapsed + 1 == DONE) begin
                m_err = 1; m_busy = 0; m_hold = 1;
            end else m_elapsed++;
        end else if (m_hold) begin
            m_hold = 0; m_partial = 0;
        end else if (bus.enable && bus.have_space) begin
            pick = -1;
            if (elig[0]) pick = 0;
            else begin
                best = 1000;
                for (int c = 1; c <= NC; c++) begin
                    d = (c > m_rr) ? c - m_rr : c + 16 - m_rr;
                    if (elig[c] && d < best) begin best = d; pick = c; end
                end
            end
            if (pick >= 0) begin
                m_sel = pick; m_partial = !full[pick]; m_start = 1;
                m_busy = 1; m_elapsed = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("start", 32'(bus.start), 32'(m_start));
        chk("sel_chan", 32'(bus.sel_chan), 32'(m_sel));
        chk("partial", 32'(bus.partial), 32'(m_partial));
        chk("overrun", 32'(bus.overrun), 32'(m_ov));
        chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));
        chk("dbg_rr", 32'(bus.debugbus[5:3]), 32'(m_rr));
        chk("dbg_low", 32'(bus.debugbus[2:0]), 32'({bus.have_space, m_fullany, m_start}));
    endtask

    task automatic step();
        for (int c = 0; c <= NC; c++) bus.chan_usedw_flat[10*c +: 10] = 10'(usedw[c]);
        model_edge();
        @(posedge rxclk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        for (int c = 0; c <= NC; c++) usedw[c] = 0;
        bus.chan_empty  = '1;
        bus.pkt_done    = 1'b0;
        bus.overrun_clr = '0;
    endtask

    task automatic wait_start(input int maxc, output int n);
        n = 0;
        do begin step(); n++; end while (!m_start && n < maxc);
        chk("start_seen", 32'(bus.start), 32'd1);
    endtask

    // pkt_done lands `cyc` edges after the start edge; drained channels empty for the HOLD edge.
    task automatic finish_pkt(input int cyc, input logic [NC:0] drain);
        repeat (cyc - 1) step();
        bus.pkt_done = 1'b1;
        step();
        bus.pkt_done = 1'b0;
        for (int c = 0; c <= NC; c++) begin
            if (drain[c]) begin usedw[c] = 0; bus.chan_empty[c] = 1'b1; end
        end
        step();
    endtask

    initial begin
        int n;
        quiet();
        bus.enable = 1'b1; bus.channels = 4'd2; bus.have_space = 1'b1;
        repeat (2) step();
        chk("rst_sel", 32'(bus.sel_chan), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        reset = 1'b0;
        step();

        // Round-robin between two full data channels.
        usedw[1] = FULL + int'($urandom_range(0, 100)); usedw[2] = FULL;
        bus.chan_empty = 3'b001;
        for (int i = 0; i < 4; i++) begin
            wait_start(20, n);
            chk("rr_sel", 32'(bus.sel_chan), 32'(exp_rr[i]));
            chk("rr_partial", 32'(bus.partial), 32'd0);
            step();
            chk("start_width", 32'(bus.start), 32'd0);
            finish_pkt(9, (i == 3) ? 3'b111 : 3'b000);
        end

        // Control channel beats a full data channel and leaves rr_ptr alone.
        usedw[0] = int'($urandom_range(1, 50)); bus.chan_empty[0] = 1'b0;
        usedw[1] = FULL; bus.chan_empty[1] = 1'b0;
        wait_start(10, n);
        chk("ctrl_first", 32'(bus.sel_chan), 32'd0);
        finish_pkt(5, 3'b001);
        chk("ctrl_rr_kept", 32'(bus.debugbus[5:3]), 32'd2);
        wait_start(10, n);
        chk("ctrl_then_data", 32'(bus.sel_chan), 32'd1);
        finish_pkt(5, 3'b111);

        // Partial flush after the age timer saturates.
        repeat (3) step();
        usedw[2] = int'($urandom_range(1, FULL - 1)); bus.chan_empty[2] = 1'b0;
        wait_start(5000, n);
        chk("flush_latency", 32'(n), 32'(FLUSH + 1));
        chk("flush_sel", 32'(bus.sel_chan), 32'd2);
        chk("flush_partial", 32'(bus.partial), 32'd1);
        finish_pkt(3, 3'b100);
        chk("partial_cleared", 32'(bus.partial), 32'd0);

        // Overrun set, grant, clear, and set-wins-over-clear.
        usedw[1] = 510; bus.chan_empty[1] = 1'b0; bus.have_space = 1'b0;
        repeat (5) step();
        chk("ovr_set", 32'(bus.overrun[1]), 32'd1);
        chk("ovr_nostart", 32'(bus.start), 32'd0);
        bus.have_space = 1'b1;
        wait_start(10, n);
        chk("ovr_grant", 32'(bus.sel_chan), 32'd1);
        finish_pkt(4, 3'b010);
        bus.overrun_clr = 3'b010; step(); bus.overrun_clr = '0;
        chk("ovr_clr", 32'(bus.overrun[1]), 32'd0);
        usedw[1] = 510; bus.chan_empty[1] = 1'b0; bus.have_space = 1'b0;
        step();
        bus.overrun_clr = 3'b010; step(); bus.overrun_clr = '0;
        chk("ovr_set_wins", 32'(bus.overrun[1]), 32'd1);
        quiet(); bus.have_space = 1'b1;
        repeat (2) step();

        // Done timeout abandons the grant; rr_ptr stays at 1 so channel 2 comes next.
        usedw[1] = 520; bus.chan_empty[1] = 1'b0;
        wait_start(10, n);
        chk("to_sel", 32'(bus.sel_chan), 32'd1);
        usedw[2] = 700; bus.chan_empty[2] = 1'b0;
        n = 0;
        do begin step(); n++; end while (!m_err && n < DONE + 100);
        chk("to_cycles", 32'(n), 32'(DONE));
        chk("to_err", 32'(bus.err_timeout), 32'd1);
        wait_start(10, n);
        chk("to_next_sel", 32'(bus.sel_chan), 32'd2);
        finish_pkt(4, 3'b111);

        // Randomized traffic, including clamped channel counts and stray pkt_done.
        for (int i = 0; i < 400; i++) begin
            bus.enable   = ($urandom_range(0, 7) != 0);
            bus.channels = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15))
                                                       : 4'($urandom_range(0, 2));
            for (int c = 0; c <= NC; c++) begin
                bus.chan_empty[c] = ($urandom_range(0, 2) == 0);
                if (bus.chan_empty[c]) usedw[c] = 0;
                else if ($urandom_range(0, 1) == 1) usedw[c] = int'($urandom_range(FULL, 1023));
                else usedw[c] = int'($urandom_range(1, FULL - 1));
            end
            bus.have_space  = ($urandom_range(0, 3) != 0);
            bus.pkt_done    = ($urandom_range(0, 5) == 0);
            bus.overrun_clr = 3'($urandom);
            step();
        end
        quiet();
        bus.enable = 1'b1; bus.have_space = 1'b1; bus.channels = 4'd2;

        // Reset in the middle of a grant; a late pkt_done must do nothing.
        usedw[1] = 600; bus.chan_empty[1] = 1'b0;
        wait_start(DONE + 100, n);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_mid_start", 32'(bus.start), 32'd0);
        chk("rst_mid_sel", 32'(bus.sel_chan), 32'd0);
        chk("rst_mid_partial", 32'(bus.partial), 32'd0);
        chk("rst_mid_err", 32'(bus.err_timeout), 32'd0);
        chk("rst_mid_ovr", 32'(bus.overrun), 32'd0);
        reset = 1'b0;
        quiet();
        bus.enable = 1'b0;
        bus.pkt_done = 1'b1; step(); bus.pkt_done = 1'b0;
        repeat (3) step();
        chk("post_rst_start", 32'(bus.start), 32'd0);
        chk("post_rst_rr", 32'(bus.debugbus[5:3]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
